pulse_period_checker: RTL

PULSE_PERIOD_CHECKER -- requirements
Module: pulse_period_checker

---
 rtl/pulse_period_checker_pkg.sv | 14 +
 rtl/pulse_period_checker_counter.sv | 26 ++
 rtl/pulse_period_checker.sv | 96 +++++++++
 3 files changed

// File: rtl/pulse_period_checker_pkg.sv
// Shared types and default parameters for the pulse period checker.
package pulse_period_checker_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int DEF_PERIOD     = 3;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_CNT_W      = 4;

endpackage

// File: rtl/pulse_period_checker_counter.sv
// Interval counter: cycles since the last pulse, restarting at 1 the cycle after a pulse.
module pulse_interval_counter #(
  parameter int CNT_W = pulse_period_checker_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturates so a long gap never wraps into a plausible interval.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (en) begin
      if (pulse_in)
        count <= CNT_W'(1);
      else if (count != CNT_MAX)
        count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pulse_period_checker.sv
// Checks that pulse_in repeats every PERIOD cycles; locks after LOCK_COUNT good intervals.
module pulse_period_checker
  import pulse_period_checker_pkg::*;
#(
  parameter int PERIOD     = DEF_PERIOD,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pulse_in,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] last_period,
  output logic [7:0]       miss_cnt
);

  localparam logic [CNT_W-1:0] PER_C  = CNT_W'(PERIOD);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_COUNT);

  state_t           state, state_n;
  logic [3:0]       good_cnt, good_n, good_inc;
  logic [CNT_W-1:0] count;
  logic             hit, viol, upd_last;

  pulse_interval_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pulse_in (pulse_in),
    .count    (count)
  );

  assign hit      = (count == PER_C);
  assign good_inc = good_cnt + 4'd1;

  always_comb begin
    state_n  = state;
    good_n   = good_cnt;
    viol     = 1'b0;
    upd_last = 1'b0;
    unique case (state)
      HUNT: begin
        if (pulse_in) begin
          state_n = TRACK;
          good_n  = 4'd0;
        end
      end
      TRACK: begin
        if (pulse_in) begin
          upd_last = 1'b1;
          if (hit) begin
            good_n = good_inc;
            if (good_inc == LOCK_C) state_n = LOCKED;
          end else
            good_n = 4'd0;
        end else if (hit)
          good_n = 4'd0;
      end
      LOCKED: begin
        // A pulse always wins over the timeout; it is judged by its interval.
        if (pulse_in) begin
          upd_last = 1'b1;
          viol     = !hit;
        end else
          viol = hit;
      end
      default: state_n = HUNT;
    endcase
    if (viol) begin
      state_n = TRACK;
      good_n  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      good_cnt    <= 4'd0;
      locked      <= 1'b0;
      err         <= 1'b0;
      last_period <= '0;
      miss_cnt    <= 8'd0;
    end else if (en) begin
      state    <= state_n;
      good_cnt <= good_n;
      locked   <= (state_n == LOCKED);
      err      <= viol;
      if (viol && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
      if (upd_last) last_period <= count;
    end else
      err <= 1'b0;
  end

endmodule
